uart_tx_arbiter: RTL and testbench

//  Shares the single uart_core transmitter between pNUM_REQ byte-stream requesters (e.g. trace

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_arbiter_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and counter widths.
// Used by the TX arbiter and the RX dispatcher.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  localparam int STALL_CNT_W = 16;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(
    input logic [STALL_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin find-first: first valid index strictly after ptr,
// wrapping around; hit is low when nothing is valid.
module rr_pick
  import uart_pkg::*;
#(
  parameter int pNUM_REQ = 4,
  parameter int pIDW     = 2
) (
  input  logic [pNUM_REQ-1:0] req_valid,
  input  logic [pIDW-1:0]     ptr,
  output logic [pIDW-1:0]     idx,
  output logic                hit
);

  logic [pIDW:0] cand;

  // scan farthest to nearest so the nearest valid index wins
  always_comb begin
    idx  = '0;
    hit  = 1'b0;
    cand = '0;
    for (int i = pNUM_REQ; i >= 1; i--) begin
      cand = {1'b0, ptr} + (pIDW+1)'(i);
      if (cand >= (pIDW+1)'(pNUM_REQ))
        cand = cand - (pIDW+1)'(pNUM_REQ);
      if (req_valid[cand[pIDW-1:0]]) begin
        idx = cand[pIDW-1:0];
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between byte-stream requesters.
// Round-robin grant held per packet; stalled packets are released.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int pNUM_REQ   = 4,
  parameter int pIDW       = 2,
  parameter int pSTALL_MAX = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [pNUM_REQ-1:0]    req_valid,
  input  logic [8*pNUM_REQ-1:0]  req_data,
  input  logic [pNUM_REQ-1:0]    req_last,
  output logic [pNUM_REQ-1:0]    req_ready,
  output logic                   txd_syn,
  output logic [7:0]             txd_data,
  input  logic                   txd_ack,
  output logic [pIDW-1:0]        grant_id,
  output logic                   busy,
  output logic                   stall_err,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int SCW = $clog2(pSTALL_MAX + 1);
  localparam logic [SCW-1:0] STALL_END = SCW'(pSTALL_MAX - 1);

  state_t          state_q;
  state_t          state_d;
  logic [pIDW-1:0] rr_ptr;
  logic [pIDW-1:0] pick_idx;
  logic            pick_hit;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;
  logic            last_q;
  logic [SCW-1:0]  stall_cnt;
  logic            grant_ld;
  logic            byte_ld;
  logic            ack_done;
  logic            stall_inc;
  logic            stall_fire;

  rr_pick #(
    .pNUM_REQ(pNUM_REQ),
    .pIDW    (pIDW)
  ) u_pick (
    .req_valid(req_valid),
    .ptr      (rr_ptr),
    .idx      (pick_idx),
    .hit      (pick_hit)
  );

  // select the granted requester's byte lane
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < pNUM_REQ; i++) begin
      if (grant_id == pIDW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_FETCH)
                   ? (pNUM_REQ'(1) << grant_id)
                   : '0;
  assign busy = (state_q != S_IDLE);

  // next-state and datapath strobes
  always_comb begin
    state_d    = state_q;
    grant_ld   = 1'b0;
    byte_ld    = 1'b0;
    ack_done   = 1'b0;
    stall_inc  = 1'b0;
    stall_fire = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable && pick_hit) begin
          grant_ld = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (sel_valid) begin
          byte_ld = 1'b1;
          state_d = S_SEND;
        end else if (stall_cnt == STALL_END) begin
          stall_fire = 1'b1;
          state_d    = S_IDLE;
        end else begin
          stall_inc = 1'b1;
        end
      end
      S_SEND: begin
        if (txd_ack) begin
          ack_done = 1'b1;
          state_d  = last_q ? S_IDLE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // grant, capture, stall tracking and UART handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id    <= '0;
      rr_ptr      <= pIDW'(pNUM_REQ - 1);
      txd_syn     <= 1'b0;
      txd_data    <= '0;
      last_q      <= 1'b0;
      stall_cnt   <= '0;
      stall_err   <= 1'b0;
      stall_count <= '0;
    end else begin
      stall_err <= stall_fire;
      if (grant_ld) begin
        grant_id  <= pick_idx;
        rr_ptr    <= pick_idx;
        stall_cnt <= '0;
      end
      if (byte_ld) begin
        txd_syn  <= 1'b1;
        txd_data <= sel_data;
        last_q   <= sel_last;
      end
      if (ack_done) begin
        txd_syn   <= 1'b0;
        stall_cnt <= '0;
      end
      if (stall_inc)
        stall_cnt <= stall_cnt + 1'b1;
      if (stall_fire)
        stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed timing cases plus randomized
// packet traffic against a packet-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            txd_syn;
  logic [7:0]      txd_data;
  logic            txd_ack;
  logic [1:0]      grant_id;
  logic            busy;
  logic            stall_err;
  logic [15:0]     stall_count;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .pNUM_REQ  (N),
    .pIDW      (2),
    .pSTALL_MAX(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .txd_syn    (txd_syn),
    .txd_data   (txd_data),
    .txd_ack    (txd_ack),
    .grant_id   (grant_id),
    .busy       (busy),
    .stall_err  (stall_err),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [8:0] mem [N][64];
  int   head  [N];
  int   tail  [N];
  int   mhead [N];
  int   gap   [N];
  logic took  [N];
  int   cur, mptr, adly, nacc, total;

  // packet-level model: packets go round robin over requesters
  // that still have data; bytes of a packet stay contiguous
  task automatic model_ack();
    logic lst;
    if (cur < 0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (mptr + k) % N;
        if (cur < 0 && mhead[j] < tail[j]) cur = j;
      end
      if (cur >= 0) mptr = cur;
    end
    if (cur >= 0) begin
      chk("rnd_grant", 32'(grant_id), 32'(cur));
      chk("rnd_data", 32'(txd_data),
          32'(mem[cur][mhead[cur]][7:0]));
      lst = mem[cur][mhead[cur]][8];
      mhead[cur]++;
      if (lst) cur = -1;
    end
    nacc++;
  endtask

  task automatic rnd_cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (took[i]) begin
        head[i]++;
        if (!mem[i][head[i]-1][8])
          gap[i] = int'($urandom_range(0, 3));
      end else if (gap[i] > 0) begin
        gap[i]--;
      end
      req_valid[i] = (head[i] < tail[i]) && (gap[i] == 0);
      req_data[8*i +: 8] = (head[i] < tail[i])
                         ? mem[i][head[i]][7:0] : 8'h00;
      req_last[i] = (head[i] < tail[i])
                  ? mem[i][head[i]][8] : 1'b0;
    end
    txd_ack = 1'b0;
    if (txd_syn) begin
      if (adly == 0) begin
        txd_ack = 1'b1;
        model_ack();
        adly = int'($urandom_range(0, 3));
      end else begin
        adly--;
      end
    end
    for (int i = 0; i < N; i++)
      took[i] = req_valid[i] & req_ready[i];
  endtask

  initial begin
    int cnt;
    int npk, len;
    reset     = 1'b1;
    enable    = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    txd_ack   = 1'b0;
    repeat (3) tick();

    chk("rst_syn",    32'(txd_syn),     32'h0);
    chk("rst_busy",   32'(busy),        32'h0);
    chk("rst_grant",  32'(grant_id),    32'h0);
    chk("rst_scount", 32'(stall_count), 32'h0);
    chk("rst_serr",   32'(stall_err),   32'h0);
    chk("rst_ready",  32'(req_ready),   32'h0);
    reset = 1'b0;
    tick();

    // latency and single-byte packet, ack held 5 cycles
    req_valid = 4'b0001;
    req_data  = 32'h0000_0011;
    req_last  = 4'b0001;
    tick();
    chk("lat_ready", 32'(req_ready), 32'h1);
    chk("lat_busy",  32'(busy),      32'h1);
    tick();
    chk("lat_syn",   32'(txd_syn),   32'h1);
    chk("lat_data",  32'(txd_data),  32'h11);
    chk("lat_rdy0",  32'(req_ready), 32'h0);
    req_valid = '0;
    txd_ack   = 1'b1;
    tick();
    chk("ack_syn_drop", 32'(txd_syn), 32'h0);
    chk("single_idle",  32'(busy),    32'h0);
    repeat (4) begin
      tick();
      chk("ack_held_idle", 32'(busy), 32'h0);
    end
    txd_ack = 1'b0;

    // stalled packet on req2, req3 waiting
    req_valid = 4'b1100;
    req_data  = 32'h5AA5_0000;
    req_last  = 4'b1000;
    tick();
    chk("stall_grant", 32'(grant_id),  32'h2);
    chk("stall_ready", 32'(req_ready), 32'h4);
    tick();
    chk("stall_syn",  32'(txd_syn),  32'h1);
    chk("stall_data", 32'(txd_data), 32'hA5);
    req_valid = 4'b1000;
    txd_ack   = 1'b1;
    tick();
    txd_ack = 1'b0;
    cnt = 0;
    while (!stall_err && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("stall_cycles", 32'(cnt),         32'd16);
    chk("stall_count",  32'(stall_count), 32'h1);
    chk("stall_busy",   32'(busy),        32'h0);
    tick();
    chk("stall_pulse", 32'(stall_err), 32'h0);
    chk("stall_next",  32'(grant_id),  32'h3);
    chk("next_ready",  32'(req_ready), 32'h8);
    tick();
    chk("next_syn",  32'(txd_syn),  32'h1);
    chk("next_data", 32'(txd_data), 32'h5A);
    txd_ack   = 1'b1;
    req_valid = '0;
    tick();
    txd_ack = 1'b0;
    chk("next_done", 32'(busy), 32'h0);

    // enable dropped mid-packet on req1, req2 waiting
    req_valid = 4'b0010;
    req_data  = 32'h0000_7100;
    req_last  = 4'b0000;
    tick();
    chk("en_grant", 32'(grant_id), 32'h1);
    tick();
    chk("en_syn1",  32'(txd_syn),  32'h1);
    chk("en_data1", 32'(txd_data), 32'h71);
    enable    = 1'b0;
    req_data  = 32'h0099_7200;
    req_last  = 4'b0110;
    req_valid = 4'b0110;
    txd_ack   = 1'b1;
    tick();
    txd_ack = 1'b0;
    chk("en_fetch", 32'(req_ready), 32'h2);
    tick();
    chk("en_syn2",  32'(txd_syn),  32'h1);
    chk("en_data2", 32'(txd_data), 32'h72);
    txd_ack   = 1'b1;
    req_valid = 4'b0100;
    tick();
    txd_ack = 1'b0;
    chk("en_done", 32'(busy), 32'h0);
    repeat (3) begin
      tick();
      chk("en_hold", 32'(busy), 32'h0);
    end
    enable = 1'b1;
    tick();
    chk("en_resume", 32'(grant_id), 32'h2);
    chk("en_busy",   32'(busy),     32'h1);

    // reset during SEND
    tick();
    chk("rst_pre_syn", 32'(txd_syn), 32'h1);
    reset = 1'b1;
    tick();
    chk("rst_mid_syn",   32'(txd_syn),  32'h0);
    chk("rst_mid_grant", 32'(grant_id), 32'h0);
    chk("rst_mid_busy",  32'(busy),     32'h0);
    reset     = 1'b0;
    req_valid = 4'b1100;
    req_data  = 32'h5A99_0000;
    req_last  = 4'b1100;
    tick();
    chk("rst_rr", 32'(grant_id), 32'h2);
    req_valid = '0;

    // randomized traffic
    reset = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    cur      = -1;
    mptr     = N - 1;
    adly     = 0;
    for (int r = 0; r < 3; r++) begin
      total = 0;
      nacc  = 0;
      for (int i = 0; i < N; i++) begin
        head[i]  = 0;
        tail[i]  = 0;
        mhead[i] = 0;
        gap[i]   = 0;
        took[i]  = 1'b0;
        npk = int'($urandom_range(1, 4));
        for (int p = 0; p < npk; p++) begin
          len = int'($urandom_range(1, 4));
          for (int b = 0; b < len; b++) begin
            mem[i][tail[i]] = {b == len - 1, 8'($urandom)};
            tail[i]++;
          end
        end
        total += tail[i];
      end
      for (int c = 0; c < 4000 && nacc < total; c++)
        rnd_cycle();
      chk("rnd_bytes", 32'(nacc), 32'(total));
      repeat (3) tick();
      chk("rnd_idle",    32'(busy),        32'h0);
      chk("rnd_nostall", 32'(stall_count), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
